encoder_frame_ctrl: RTL and testbench

//  Frame sequencer for the rate-1/2 convolutional encoder (encoder2).
//  - Accepts a frame of FRAME_LEN-or-runtime-length info bits over a valid/ready source interface.
//  - Drives the encoder's enable_i/d_in, then appends TAIL_LEN zero bits so the trellis returns to state 0.
//  - Tags the encoder's output symbols with start/end-of-frame markers for the Viterbi decoder path.

---
 rtl/encoder_frame_ctrl_if.sv | 41 ++++
 rtl/encoder_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_encoder_frame_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_frame_ctrl_if.sv
// Source/encoder/symbol bundle between the frame controller and its neighbours.
// Master side drives start/length/abort, source bits and encoder outputs.
// Slave side (the controller) drives ready, encoder inputs and tagged symbols.
interface encoder_frame_ctrl_if #(
    parameter int MAX_LEN = 256
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic             start_i;
    logic [LEN_W-1:0] frame_len_i;
    logic             abort_i;
    logic             src_valid_i;
    logic             src_data_i;
    logic             src_ready_o;
    logic             enc_enable_o;
    logic             enc_d_o;
    logic             enc_valid_i;
    logic [1:0]       enc_d_out_i;
    logic [1:0]       sym_o;
    logic             sym_valid_o;
    logic             sof_o;
    logic             eof_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic             aborted_o;

    modport master (
        output start_i, frame_len_i, abort_i, src_valid_i, src_data_i,
               enc_valid_i, enc_d_out_i,
        input  src_ready_o, enc_enable_o, enc_d_o, sym_o, sym_valid_o,
               sof_o, eof_o, busy_o, done_o, err_o, aborted_o
    );

    modport slave (
        input  start_i, frame_len_i, abort_i, src_valid_i, src_data_i,
               enc_valid_i, enc_d_out_i,
        output src_ready_o, enc_enable_o, enc_d_o, sym_o, sym_valid_o,
               sof_o, eof_o, busy_o, done_o, err_o, aborted_o
    );
endinterface

// File: rtl/encoder_frame_ctrl.sv
// Frame sequencer for the rate-1/2 K=3 encoder: feeds info bits, appends zero tail, tags sof/eof.
// Latency: source bit -> enc_enable_o/enc_d_o 1 cycle; sof/eof realigned to encoder output by ENC_LAT.
// Backpressure: src_ready_o high only in DATA; missing src_valid_i inserts a bubble (no enable).
module encoder_frame_ctrl #(
    parameter int MAX_LEN  = 256,
    parameter int TAIL_LEN = 2,
    parameter int ENC_LAT  = 1
) (
    input logic                clk,
    input logic                rst,
    encoder_frame_ctrl_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int TW    = $clog2(TAIL_LEN + 1);
    localparam int DW    = $clog2(ENC_LAT + 1);

    typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [TW-1:0]    tail_cnt, tail_nxt;
    logic [DW-1:0]    drain_cnt, drain_nxt;
    logic             first_q, first_nxt;
    logic             aborted_q, aborted_nxt;
    logic             en_q, en_nxt;
    logic             d_q, d_nxt;
    logic             sof_q, sof_nxt;
    logic             eof_q, eof_nxt;
    logic             done_q, done_nxt;
    logic             err_q, err_nxt;
    logic             len_ok;
    logic [ENC_LAT-1:0] sof_pipe, eof_pipe;

    assign len_ok = (bus.frame_len_i != '0) && (bus.frame_len_i <= LEN_W'(MAX_LEN));

    // Next-state and next-output decode; every target defaults to hold or idle first.
    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        cnt_nxt     = cnt;
        tail_nxt    = tail_cnt;
        drain_nxt   = drain_cnt;
        first_nxt   = first_q;
        aborted_nxt = aborted_q;
        en_nxt      = 1'b0;
        d_nxt       = 1'b0;
        sof_nxt     = 1'b0;
        eof_nxt     = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    if (len_ok) begin
                        len_nxt     = bus.frame_len_i;
                        cnt_nxt     = '0;
                        aborted_nxt = 1'b0;
                        first_nxt   = 1'b1;
                        state_nxt   = DATA;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.abort_i) begin
                    // Abort wins over a same-cycle source bit, which is dropped.
                    aborted_nxt = 1'b1;
                    cnt_nxt     = '0;
                    tail_nxt    = '0;
                    state_nxt   = TAIL;
                end else if (bus.src_valid_i) begin
                    en_nxt    = 1'b1;
                    d_nxt     = bus.src_data_i;
                    sof_nxt   = first_q;
                    first_nxt = 1'b0;
                    if (cnt == len_q - LEN_W'(1)) begin
                        cnt_nxt   = '0;
                        tail_nxt  = '0;
                        state_nxt = TAIL;
                    end else begin
                        cnt_nxt = cnt + LEN_W'(1);
                    end
                end
            end
            TAIL: begin
                // A frame aborted before any data still gets its sof on the first tail bit.
                en_nxt    = 1'b1;
                sof_nxt   = first_q;
                first_nxt = 1'b0;
                if (tail_cnt == TW'(TAIL_LEN - 1)) begin
                    eof_nxt   = 1'b1;
                    drain_nxt = '0;
                    state_nxt = DRAIN;
                end else begin
                    tail_nxt = tail_cnt + TW'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == DW'(ENC_LAT - 1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    drain_nxt = drain_cnt + DW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and registered encoder/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            tail_cnt  <= '0;
            drain_cnt <= '0;
            first_q   <= 1'b0;
            aborted_q <= 1'b0;
            en_q      <= 1'b0;
            d_q       <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            len_q     <= len_nxt;
            cnt       <= cnt_nxt;
            tail_cnt  <= tail_nxt;
            drain_cnt <= drain_nxt;
            first_q   <= first_nxt;
            aborted_q <= aborted_nxt;
            en_q      <= en_nxt;
            d_q       <= d_nxt;
            sof_q     <= sof_nxt;
            eof_q     <= eof_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

    // Delay the frame markers by the encoder latency so they line up with its output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sof_pipe <= '0;
            eof_pipe <= '0;
        end else begin
            sof_pipe[0] <= sof_q;
            eof_pipe[0] <= eof_q;
            for (int i = 1; i < ENC_LAT; i++) begin
                sof_pipe[i] <= sof_pipe[i-1];
                eof_pipe[i] <= eof_pipe[i-1];
            end
        end
    end

    assign bus.src_ready_o  = (state == DATA);
    assign bus.busy_o       = (state != IDLE);
    assign bus.enc_enable_o = en_q;
    assign bus.enc_d_o      = d_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;
    assign bus.aborted_o    = aborted_q;
    assign bus.sym_o        = bus.enc_d_out_i;
    assign bus.sym_valid_o  = bus.enc_valid_i;
    assign bus.sof_o        = sof_pipe[ENC_LAT-1] & bus.enc_valid_i;
    assign bus.eof_o        = eof_pipe[ENC_LAT-1] & bus.enc_valid_i;
endmodule

// File: tb/tb_encoder_frame_ctrl.sv
// Directed bench for encoder_frame_ctrl with a behavioural K=3 encoder behind it.
module tb_encoder_frame_ctrl;
    localparam int MAX_LEN = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    encoder_frame_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

    encoder_frame_ctrl #(.MAX_LEN(MAX_LEN), .TAIL_LEN(2), .ENC_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Encoder stand-in: one-cycle latency, generators 7/5.
    logic [1:0] enc_sr;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_sr          <= 2'b00;
            bus.enc_valid_i <= 1'b0;
            bus.enc_d_out_i <= 2'b00;
        end else begin
            bus.enc_valid_i <= bus.enc_enable_o;
            if (bus.enc_enable_o) begin
                bus.enc_d_out_i <= {bus.enc_d_o ^ enc_sr[1] ^ enc_sr[0], bus.enc_d_o ^ enc_sr[0]};
                enc_sr          <= {bus.enc_d_o, enc_sr[1]};
            end
        end
    end

    int chk = 0;
    int pass = 0;

    int          en_cnt, sym_cnt, sof_cnt, eof_cnt, sof_idx, eof_idx;
    int          done_cnt, err_cnt, sym_mis, stray;
    logic [31:0] en_bits, en_trace;
    bit          last_done, done_on_eof;

    task automatic mon_clear();
        en_cnt = 0; sym_cnt = 0; sof_cnt = 0; eof_cnt = 0; sof_idx = 0; eof_idx = 0;
        done_cnt = 0; err_cnt = 0; sym_mis = 0; stray = 0;
        en_bits = '0; en_trace = '0; last_done = 1'b0; done_on_eof = 1'b0;
    endtask

    // Advance one cycle and sample outputs on the falling edge.
    task automatic tick();
        @(negedge clk);
        en_trace = {en_trace[30:0], bus.enc_enable_o};
        if (bus.enc_enable_o) begin
            en_cnt++;
            en_bits = {en_bits[30:0], bus.enc_d_o};
        end
        if (bus.sym_valid_o) begin
            sym_cnt++;
            if (bus.sym_o !== bus.enc_d_out_i) sym_mis++;
            if (bus.sof_o) begin sof_cnt++; sof_idx = sym_cnt; end
            if (bus.eof_o) begin eof_cnt++; eof_idx = sym_cnt; end
        end else if (bus.sof_o || bus.eof_o) begin
            stray++;
        end
        last_done = bus.done_o;
        if (bus.done_o) begin
            done_cnt++;
            done_on_eof = bus.eof_o && bus.sym_valid_o;
        end
        if (bus.err_o) err_cnt++;
    endtask

    task automatic start_frame(input int len);
        bus.start_i     = 1'b1;
        bus.frame_len_i = 9'(len);
        tick();
        bus.start_i     = 1'b0;
    endtask

    // Push n bits (MSB first) back-to-back; ok drops if the controller stops accepting.
    task automatic stream(input logic [31:0] bits, input int n, output bit ok);
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < n && guard < 200) begin
            bus.src_valid_i = 1'b1;
            bus.src_data_i  = bits[n-1-i];
            acc = bus.src_ready_o;
            tick();
            if (acc) i++;
            guard++;
        end
        bus.src_valid_i = 1'b0;
        bus.src_data_i  = 1'b0;
        ok = (i == n);
    endtask

    task automatic run_until_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (last_done) begin ok = 1'b1; break; end
        end
    endtask

    function automatic logic [10:0] out_vec();
        return {bus.busy_o, bus.src_ready_o, bus.enc_enable_o, bus.enc_d_o, bus.sym_valid_o,
                bus.sym_o, bus.sof_o, bus.eof_o, bus.done_o, bus.err_o};
    endfunction

    task automatic test_reset();
        tick(); tick();
        chk++; if (out_vec() !== '0 || bus.aborted_o !== 1'b0) $display("FAIL reset_outputs: got %b/%b want 0", out_vec(), bus.aborted_o); else pass++;
        rst = 1'b1;
        tick();
        chk++; if (bus.busy_o !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", bus.busy_o); else pass++;
    endtask

    task automatic test_back_to_back();
        bit ok, okd;
        mon_clear();
        start_frame(8);
        chk++; if (bus.busy_o !== 1'b1 || bus.src_ready_o !== 1'b1) $display("FAIL t1_busy_ready: got %b%b want 11", bus.busy_o, bus.src_ready_o); else pass++;
        stream(32'b10001001, 8, ok);
        run_until_done(okd);
        chk++; if (!ok || !okd) $display("FAIL t1_progress: got stream=%0d done=%0d want 1/1", ok, okd); else pass++;
        chk++; if (en_cnt !== 10) $display("FAIL t1_enables: got %0d want 10", en_cnt); else pass++;
        chk++; if (en_bits[9:0] !== 10'b1000100100) $display("FAIL t1_enc_d: got %b want 1000100100", en_bits[9:0]); else pass++;
        chk++; if (sym_cnt !== 10 || sym_mis !== 0) $display("FAIL t1_symbols: got %0d (mis %0d) want 10 (0)", sym_cnt, sym_mis); else pass++;
        chk++; if (sof_idx !== 1 || sof_cnt !== 1) $display("FAIL t1_sof: got idx %0d cnt %0d want 1/1", sof_idx, sof_cnt); else pass++;
        chk++; if (eof_idx !== 10 || eof_cnt !== 1) $display("FAIL t1_eof: got idx %0d cnt %0d want 10/1", eof_idx, eof_cnt); else pass++;
        chk++; if (done_cnt !== 1 || !done_on_eof) $display("FAIL t1_done: got cnt %0d on_eof %0d want 1/1", done_cnt, done_on_eof); else pass++;
        tick();
        chk++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.aborted_o !== 1'b0) $display("FAIL t1_idle_after: got %b%b%b want 000", bus.busy_o, bus.done_o, bus.aborted_o); else pass++;
        chk++; if (stray !== 0) $display("FAIL t1_stray_marks: got %0d want 0", stray); else pass++;
    endtask

    task automatic test_bubbles();
        logic [3:0] bits = 4'b1101;
        int i = 0;
        bit v = 1'b1;
        bit acc, okd;
        mon_clear();
        start_frame(4);
        while (i < 4 && en_trace[31] == 1'b0) begin
            bus.src_valid_i = v;
            bus.src_data_i  = bits[3-i];
            acc = v && bus.src_ready_o;
            tick();
            if (acc) i++;
            v = !v;
        end
        bus.src_valid_i = 1'b0;
        run_until_done(okd);
        chk++; if (!okd) $display("FAIL t2_done_timeout: got 0 want 1"); else pass++;
        chk++; if (en_trace[10:0] !== 11'b01010101110) $display("FAIL t2_enable_gaps: got %b want 01010101110", en_trace[10:0]); else pass++;
        chk++; if (en_cnt !== 6 || en_bits[5:0] !== 6'b110100) $display("FAIL t2_enc_d: got %0d/%b want 6/110100", en_cnt, en_bits[5:0]); else pass++;
        chk++; if (sym_cnt !== 6 || sof_idx !== 1 || eof_idx !== 6) $display("FAIL t2_symbols: got %0d sof %0d eof %0d want 6/1/6", sym_cnt, sof_idx, eof_idx); else pass++;
    endtask

    task automatic test_abort();
        bit ok, okd;
        mon_clear();
        start_frame(8);
        stream(32'b101, 3, ok);
        bus.abort_i     = 1'b1;
        bus.src_valid_i = 1'b1;
        bus.src_data_i  = 1'b1;
        tick();
        bus.abort_i     = 1'b0;
        bus.src_valid_i = 1'b0;
        run_until_done(okd);
        chk++; if (!ok || !okd) $display("FAIL t3_progress: got stream=%0d done=%0d want 1/1", ok, okd); else pass++;
        chk++; if (en_cnt !== 5 || en_bits[4:0] !== 5'b10100) $display("FAIL t3_enc_d: got %0d/%b want 5/10100", en_cnt, en_bits[4:0]); else pass++;
        chk++; if (sym_cnt !== 5 || sof_idx !== 1 || eof_idx !== 5) $display("FAIL t3_symbols: got %0d sof %0d eof %0d want 5/1/5", sym_cnt, sof_idx, eof_idx); else pass++;
        chk++; if (bus.aborted_o !== 1'b1 || done_cnt !== 1) $display("FAIL t3_aborted: got %b done %0d want 1/1", bus.aborted_o, done_cnt); else pass++;
    endtask

    task automatic test_bad_len();
        mon_clear();
        start_frame(0);
        chk++; if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0) $display("FAIL t4_len0: got err %b busy %b want 1/0", bus.err_o, bus.busy_o); else pass++;
        tick();
        chk++; if (bus.err_o !== 1'b0) $display("FAIL t4_err_pulse: got %b want 0", bus.err_o); else pass++;
        start_frame(MAX_LEN + 1);
        chk++; if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0) $display("FAIL t4_len_over: got err %b busy %b want 1/0", bus.err_o, bus.busy_o); else pass++;
        bus.abort_i = 1'b1;
        tick(); tick();
        bus.abort_i = 1'b0;
        chk++; if (err_cnt !== 2 || bus.busy_o !== 1'b0 || en_cnt !== 0) $display("FAIL t4_idle: got err %0d busy %b en %0d want 2/0/0", err_cnt, bus.busy_o, en_cnt); else pass++;
        chk++; if (bus.aborted_o !== 1'b1) $display("FAIL t4_aborted_sticky: got %b want 1", bus.aborted_o); else pass++;
    endtask

    task automatic test_start_in_tail();
        bit ok, okd;
        mon_clear();
        start_frame(2);
        stream(32'b11, 2, ok);
        bus.start_i     = 1'b1;
        bus.frame_len_i = 9'd5;
        tick(); tick();
        bus.start_i     = 1'b0;
        run_until_done(okd);
        tick();
        chk++; if (!ok || !okd || en_cnt !== 4 || err_cnt !== 0) $display("FAIL t5_ignored_start: got en %0d err %0d ok %0d%0d want 4/0/11", en_cnt, err_cnt, ok, okd); else pass++;
        chk++; if (bus.busy_o !== 1'b0 || bus.aborted_o !== 1'b0) $display("FAIL t5_idle: got busy %b aborted %b want 0/0", bus.busy_o, bus.aborted_o); else pass++;
        mon_clear();
        start_frame(1);
        stream(32'b1, 1, ok);
        run_until_done(okd);
        chk++; if (sym_cnt !== 3 || sof_idx !== 1 || eof_idx !== 3) $display("FAIL t5_len1: got %0d sof %0d eof %0d want 3/1/3", sym_cnt, sof_idx, eof_idx); else pass++;
        chk++; if (en_bits[2:0] !== 3'b100 || done_cnt !== 1) $display("FAIL t5_len1_bits: got %b done %0d want 100/1", en_bits[2:0], done_cnt); else pass++;
    endtask

    task automatic test_reset_mid_frame();
        bit ok, okd;
        mon_clear();
        start_frame(8);
        stream(32'b111, 3, ok);
        bus.src_valid_i = 1'b1;
        rst = 1'b0;
        #1;
        chk++; if (out_vec() !== '0 || bus.aborted_o !== 1'b0) $display("FAIL t6_async_reset: got %b/%b want 0", out_vec(), bus.aborted_o); else pass++;
        tick(); tick();
        bus.src_valid_i = 1'b0;
        rst = 1'b1;
        tick(); tick();
        chk++; if (done_cnt !== 0 || bus.busy_o !== 1'b0) $display("FAIL t6_no_done: got done %0d busy %b want 0/0", done_cnt, bus.busy_o); else pass++;
        mon_clear();
        start_frame(3);
        stream(32'b011, 3, ok);
        run_until_done(okd);
        chk++; if (!okd || en_cnt !== 5 || en_bits[4:0] !== 5'b01100) $display("FAIL t6_next_frame: got en %0d bits %b want 5/01100", en_cnt, en_bits[4:0]); else pass++;
        chk++; if (sym_cnt !== 5 || sof_idx !== 1 || eof_idx !== 5 || done_cnt !== 1) $display("FAIL t6_next_symbols: got %0d sof %0d eof %0d done %0d want 5/1/5/1", sym_cnt, sof_idx, eof_idx, done_cnt); else pass++;
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.frame_len_i = '0;
        bus.abort_i     = 1'b0;
        bus.src_valid_i = 1'b0;
        bus.src_data_i  = 1'b0;
        mon_clear();
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_abort();
        test_bad_len();
        test_start_in_tail();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
